// File: rtl/eeg_fram_master.sv
// EEG FRAM burst master: write bursts from a source stream,
// read bursts with credit-limited issue and a return FIFO.
module eeg_fram_master #(
  parameter int ADD_AW  = 12,
  parameter int DAT_DW  = 4,
  parameter int LEN_DW  = 12,
  parameter int CRD_NUM = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              CMD_VLD,
  output logic              CMD_RDY,
  input  logic              CMD_OP,
  input  logic [ADD_AW-1:0] CMD_BASE,
  input  logic [LEN_DW-1:0] CMD_LEN,
  input  logic              CMD_END,
  input  logic              SRC_VLD,
  output logic              SRC_RDY,
  input  logic [DAT_DW-1:0] SRC_DAT,
  output logic              ETOF_DAT_VLD,
  output logic              ETOF_DAT_LST,
  input  logic              ETOF_DAT_RDY,
  output logic [ADD_AW-1:0] ETOF_DAT_ADD,
  output logic [DAT_DW-1:0] ETOF_DAT_DAT,
  output logic              ETOF_ADD_VLD,
  output logic              ETOF_ADD_LST,
  output logic              ETOF_ADD_END,
  input  logic              ETOF_ADD_RDY,
  output logic [ADD_AW-1:0] ETOF_ADD_ADD,
  input  logic              FTOE_DAT_VLD,
  input  logic              FTOE_DAT_LST,
  output logic              FTOE_DAT_RDY,
  input  logic [DAT_DW-1:0] FTOE_DAT_DAT,
  output logic              SNK_VLD,
  output logic              SNK_LST,
  input  logic              SNK_RDY,
  output logic [DAT_DW-1:0] SNK_DAT,
  output logic              DONE,
  output logic              BUSY
);

  localparam int PW  = $clog2(CRD_NUM);
  localparam int PTW = PW + 1;
  localparam int CW  = PW + 1;

  typedef enum logic [1:0] {
    IDLE, WR, RD_ISS, RD_DRN
  } state_e;

  state_e            state_q;
  logic [ADD_AW-1:0] base_q;
  logic [LEN_DW-1:0] len_q;
  logic [LEN_DW-1:0] idx_q;
  logic              end_q;
  logic              done_q;
  logic [CW-1:0]     crd_q;
  logic [PTW-1:0]    wp_q;
  logic [PTW-1:0]    rp_q;
  logic [DAT_DW:0]   mem_q [CRD_NUM];

  logic              in_wr;
  logic              in_iss;
  logic [ADD_AW-1:0] addr;
  logic              is_lst;
  logic              wr_xf;
  logic              ad_vld;
  logic              ad_xf;
  logic              empty;
  logic              snk_xf;
  logic [DAT_DW:0]   head;

  assign in_wr  = (state_q == WR);
  assign in_iss = (state_q == RD_ISS);
  assign addr   = base_q + ADD_AW'(idx_q);
  assign is_lst = (idx_q == len_q);
  assign wr_xf  = in_wr & SRC_VLD & ETOF_DAT_RDY;
  assign ad_vld = in_iss & (crd_q != '0);
  assign ad_xf  = ad_vld & ETOF_ADD_RDY;
  assign empty  = (wp_q == rp_q);
  assign snk_xf = !empty & SNK_RDY;
  assign head   = mem_q[rp_q[PW-1:0]];

  assign CMD_RDY      = (state_q == IDLE);
  assign BUSY         = (state_q != IDLE);
  assign DONE         = done_q;
  assign SRC_RDY      = in_wr & ETOF_DAT_RDY;
  assign ETOF_DAT_VLD = in_wr & SRC_VLD;
  assign ETOF_DAT_LST = in_wr & is_lst;
  assign ETOF_DAT_ADD = in_wr ? addr : '0;
  assign ETOF_DAT_DAT = in_wr ? SRC_DAT : '0;
  assign ETOF_ADD_VLD = ad_vld;
  assign ETOF_ADD_LST = in_iss & is_lst;
  assign ETOF_ADD_END = in_iss & is_lst & end_q;
  assign ETOF_ADD_ADD = in_iss ? addr : '0;
  assign FTOE_DAT_RDY = 1'b1;
  assign SNK_VLD      = !empty;
  assign SNK_LST      = !empty & head[DAT_DW];
  assign SNK_DAT      = empty ? '0 : head[DAT_DW-1:0];

  // Burst sequencing: command latch, word index, completion pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      base_q  <= '0;
      len_q   <= '0;
      end_q   <= 1'b0;
      idx_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (CMD_VLD) begin
            base_q  <= CMD_BASE;
            len_q   <= CMD_LEN;
            end_q   <= CMD_END;
            idx_q   <= '0;
            state_q <= CMD_OP ? RD_ISS : WR;
          end
        end
        WR: begin
          if (wr_xf) begin
            if (is_lst) begin
              state_q <= IDLE;
              done_q  <= 1'b1;
            end else begin
              idx_q <= idx_q + LEN_DW'(1);
            end
          end
        end
        RD_ISS: begin
          if (ad_xf) begin
            if (is_lst) state_q <= RD_DRN;
            else        idx_q   <= idx_q + LEN_DW'(1);
          end
        end
        RD_DRN: begin
          if (snk_xf && head[DAT_DW]) begin
            state_q <= IDLE;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Read credits: one per free return-FIFO slot
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crd_q <= CW'(CRD_NUM);
    end else if (ad_xf != snk_xf) begin
      crd_q <= ad_xf ? crd_q - CW'(1) : crd_q + CW'(1);
    end
  end

  // Return FIFO: every FTOE beat is accepted unconditionally
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp_q <= '0;
      rp_q <= '0;
      for (int i = 0; i < CRD_NUM; i++) mem_q[i] <= '0;
    end else begin
      if (FTOE_DAT_VLD) begin
        mem_q[wp_q[PW-1:0]] <= {FTOE_DAT_LST, FTOE_DAT_DAT};
        wp_q <= wp_q + PTW'(1);
      end
      if (snk_xf) rp_q <= rp_q + PTW'(1);
    end
  end

endmodule

// File: tb/tb_eeg_fram_master.sv
// Bench for eeg_fram_master: FRAM model with 1-3 cycle latency,
// scoreboard of expected beats, directed bursts with literal pins.
module tb_eeg_fram_master;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        CMD_VLD = 1'b0;
  logic        CMD_RDY;
  logic        CMD_OP = 1'b0;
  logic [11:0] CMD_BASE = '0;
  logic [11:0] CMD_LEN = '0;
  logic        CMD_END = 1'b0;
  logic        SRC_VLD = 1'b0;
  logic        SRC_RDY;
  logic [3:0]  SRC_DAT = '0;
  logic        ETOF_DAT_VLD, ETOF_DAT_LST;
  logic        ETOF_DAT_RDY = 1'b1;
  logic [11:0] ETOF_DAT_ADD;
  logic [3:0]  ETOF_DAT_DAT;
  logic        ETOF_ADD_VLD, ETOF_ADD_LST, ETOF_ADD_END;
  logic        ETOF_ADD_RDY = 1'b1;
  logic [11:0] ETOF_ADD_ADD;
  logic        FTOE_DAT_VLD = 1'b0;
  logic        FTOE_DAT_LST = 1'b0;
  logic        FTOE_DAT_RDY;
  logic [3:0]  FTOE_DAT_DAT = '0;
  logic        SNK_VLD, SNK_LST;
  logic        SNK_RDY = 1'b1;
  logic [3:0]  SNK_DAT;
  logic        DONE, BUSY;

  always #5 clk = ~clk;

  eeg_fram_master dut (
    .clk(clk), .rst_n(rst_n),
    .CMD_VLD(CMD_VLD), .CMD_RDY(CMD_RDY), .CMD_OP(CMD_OP),
    .CMD_BASE(CMD_BASE), .CMD_LEN(CMD_LEN), .CMD_END(CMD_END),
    .SRC_VLD(SRC_VLD), .SRC_RDY(SRC_RDY), .SRC_DAT(SRC_DAT),
    .ETOF_DAT_VLD(ETOF_DAT_VLD), .ETOF_DAT_LST(ETOF_DAT_LST),
    .ETOF_DAT_RDY(ETOF_DAT_RDY), .ETOF_DAT_ADD(ETOF_DAT_ADD),
    .ETOF_DAT_DAT(ETOF_DAT_DAT),
    .ETOF_ADD_VLD(ETOF_ADD_VLD), .ETOF_ADD_LST(ETOF_ADD_LST),
    .ETOF_ADD_END(ETOF_ADD_END), .ETOF_ADD_RDY(ETOF_ADD_RDY),
    .ETOF_ADD_ADD(ETOF_ADD_ADD),
    .FTOE_DAT_VLD(FTOE_DAT_VLD), .FTOE_DAT_LST(FTOE_DAT_LST),
    .FTOE_DAT_RDY(FTOE_DAT_RDY), .FTOE_DAT_DAT(FTOE_DAT_DAT),
    .SNK_VLD(SNK_VLD), .SNK_LST(SNK_LST), .SNK_RDY(SNK_RDY),
    .SNK_DAT(SNK_DAT), .DONE(DONE), .BUSY(BUSY)
  );

  typedef struct {
    int         t;
    logic [11:0] a;
    logic       l;
  } pend_t;

  int          vec = 0;
  int          errs = 0;
  int          cyc = 0;
  int          last_t = 0;
  int          outst = 0;
  int          done_cnt = 0;
  int          snk_cnt = 0;
  bit          busy_m = 1'b0;
  bit          done_exp = 1'b0;
  bit          cmd_seen = 1'b0;
  bit          xf_src = 1'b0;
  bit          rnd_on = 1'b0;
  bit          snk_block = 1'b0;
  logic [3:0]  fram [4096];
  logic [3:0]  ref_mem [4096];
  logic [16:0] exp_wr [$];
  logic [13:0] exp_ad [$];
  logic [4:0]  exp_snk [$];
  logic [3:0]  src_q [$];
  pend_t       pend [$];
  logic [11:0] ad_log [$];
  logic [1:0]  le_log [$];
  logic [4:0]  snk_log [$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Compare process: checks and scoreboard updates away from the edge
  always @(negedge clk) begin
    logic [16:0] ew;
    logic [13:0] ea;
    logic [4:0]  es;
    pend_t       p;
    xf_src = 1'b0;
    if (rst_n) begin
      chk("ftoe_rdy", FTOE_DAT_RDY, 1);
      chk("busy", BUSY, busy_m);
      chk("cmd_rdy", CMD_RDY, !busy_m);
      chk("done", DONE, done_exp);
      if (!busy_m)
        chk("idle_quiet", {ETOF_DAT_VLD, ETOF_ADD_VLD, SRC_RDY}, 0);
      if (DONE) done_cnt++;
      done_exp = 1'b0;
      xf_src = SRC_VLD && SRC_RDY;
      if (CMD_VLD && CMD_RDY) begin
        busy_m = 1'b1;
        cmd_seen = 1'b1;
      end
      if (ETOF_DAT_VLD && ETOF_DAT_RDY) begin
        chk("wr_expected", exp_wr.size() > 0, 1);
        if (exp_wr.size() > 0) begin
          ew = exp_wr.pop_front();
          chk("wr_beat", {ETOF_DAT_LST, ETOF_DAT_ADD, ETOF_DAT_DAT}, ew);
          if (ew[16]) begin
            busy_m = 1'b0;
            done_exp = 1'b1;
          end
        end
        fram[ETOF_DAT_ADD] = ETOF_DAT_DAT;
      end
      if (ETOF_ADD_VLD && ETOF_ADD_RDY) begin
        chk("ad_expected", exp_ad.size() > 0, 1);
        if (exp_ad.size() > 0) begin
          ea = exp_ad.pop_front();
          chk("rd_addr", {ETOF_ADD_END, ETOF_ADD_LST, ETOF_ADD_ADD}, ea);
        end
        ad_log.push_back(ETOF_ADD_ADD);
        le_log.push_back({ETOF_ADD_LST, ETOF_ADD_END});
        outst++;
        chk("outstanding_le_4", outst <= 4, 1);
        p.t = cyc + $urandom_range(1, 3);
        if (p.t <= last_t) p.t = last_t + 1;
        last_t = p.t;
        p.a = ETOF_ADD_ADD;
        p.l = ETOF_ADD_LST;
        pend.push_back(p);
      end
      if (SNK_VLD && SNK_RDY) begin
        chk("snk_expected", exp_snk.size() > 0, 1);
        if (exp_snk.size() > 0) begin
          es = exp_snk.pop_front();
          chk("snk_beat", {SNK_LST, SNK_DAT}, es);
          if (es[4]) begin
            busy_m = 1'b0;
            done_exp = 1'b1;
          end
        end
        snk_log.push_back({SNK_LST, SNK_DAT});
        snk_cnt++;
        outst--;
      end
    end
  end

  // Environment: source stream, FRAM return path, ready patterns
  always @(posedge clk) begin
    pend_t p;
    #1;
    cyc++;
    if (!rst_n) begin
      pend.delete();
      src_q.delete();
      SRC_VLD = 1'b0;
      FTOE_DAT_VLD = 1'b0;
      FTOE_DAT_LST = 1'b0;
      FTOE_DAT_DAT = '0;
    end else begin
      if (xf_src) begin
        void'(src_q.pop_front());
        SRC_VLD = 1'b0;
      end
      if (!SRC_VLD)
        SRC_VLD = (src_q.size() > 0) &&
                  (!rnd_on || $urandom_range(0, 3) != 0);
      SRC_DAT = (src_q.size() > 0) ? src_q[0] : 4'h0;
      if (pend.size() > 0 && pend[0].t <= cyc) begin
        p = pend.pop_front();
        FTOE_DAT_VLD = 1'b1;
        FTOE_DAT_DAT = fram[p.a];
        FTOE_DAT_LST = p.l;
      end else begin
        FTOE_DAT_VLD = 1'b0;
      end
      ETOF_DAT_RDY = !rnd_on || $urandom_range(0, 2) != 0;
      ETOF_ADD_RDY = !rnd_on || $urandom_range(0, 2) != 0;
      SNK_RDY = !snk_block && (!rnd_on || $urandom_range(0, 2) != 0);
    end
  end

  task automatic wait_done();
    int n = 0;
    while (busy_m && n < 3000) begin
      @(posedge clk);
      n++;
    end
    chk("done_timeout", busy_m, 0);
    @(posedge clk);
    #2;
    chk("queues_empty", exp_wr.size() + exp_ad.size() + exp_snk.size(), 0);
  endtask

  task automatic send_cmd(input bit op, input logic [11:0] base,
                          input logic [11:0] len, input bit en,
                          input bit wt, input bit seq);
    int n = 0;
    logic [11:0] a;
    logic [3:0]  d;
    @(posedge clk);
    #2;
    for (int i = 0; i <= int'(len); i++) begin
      a = base + 12'(i);
      if (!op) begin
        d = seq ? 4'(i + 1) : 4'($urandom_range(0, 15));
        exp_wr.push_back({i == int'(len), a, d});
        ref_mem[a] = d;
        src_q.push_back(d);
      end else begin
        exp_ad.push_back({en && i == int'(len), i == int'(len), a});
        exp_snk.push_back({i == int'(len), ref_mem[a]});
      end
    end
    cmd_seen = 1'b0;
    CMD_VLD = 1'b1;
    CMD_OP = op;
    CMD_BASE = base;
    CMD_LEN = len;
    CMD_END = en;
    while (!cmd_seen && n < 200) begin
      @(posedge clk);
      n++;
    end
    chk("cmd_accept", cmd_seen, 1);
    #2;
    CMD_VLD = 1'b0;
    CMD_OP = 1'b0;
    CMD_BASE = '0;
    CMD_LEN = '0;
    CMD_END = 1'b0;
    if (wt) wait_done();
  endtask

  // Call just after a rising edge
  task automatic do_reset();
    #3;
    rst_n = 1'b0;
    CMD_VLD = 1'b0;
    busy_m = 1'b0;
    done_exp = 1'b0;
    outst = 0;
    exp_wr.delete();
    exp_ad.delete();
    exp_snk.delete();
    #1;
    chk("rst_cmd_rdy", CMD_RDY, 1);
    chk("rst_busy", BUSY, 0);
    chk("rst_done", DONE, 0);
    chk("rst_src_rdy", SRC_RDY, 0);
    chk("rst_etof_ctl", {ETOF_DAT_VLD, ETOF_DAT_LST, ETOF_ADD_VLD,
                         ETOF_ADD_LST, ETOF_ADD_END}, 0);
    chk("rst_addrs", {ETOF_DAT_ADD, ETOF_ADD_ADD, ETOF_DAT_DAT}, 0);
    chk("rst_snk", {SNK_VLD, SNK_LST, SNK_DAT}, 0);
    chk("rst_ftoe_rdy", FTOE_DAT_RDY, 1);
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
  endtask

  initial begin
    int d0;
    int s0;
    int n;
    for (int i = 0; i < 4096; i++) begin
      fram[i] = 4'(i ^ (i >> 4));
      ref_mem[i] = fram[i];
    end
    @(posedge clk);
    do_reset();

    // Write burst 0x010..0x013 with data 1..4
    d0 = done_cnt;
    send_cmd(1'b0, 12'h010, 12'd3, 1'b0, 1'b1, 1'b1);
    chk("t035_m10", fram[12'h010], 4'h1);
    chk("t035_m11", fram[12'h011], 4'h2);
    chk("t035_m12", fram[12'h012], 4'h3);
    chk("t035_m13", fram[12'h013], 4'h4);
    chk("t035_done", done_cnt - d0, 1);
    chk("t035_cmd_rdy", CMD_RDY, 1);

    // Read burst wrapping the top of the address space
    ad_log.delete();
    le_log.delete();
    send_cmd(1'b1, 12'hFFE, 12'd3, 1'b1, 1'b1, 1'b0);
    chk("t036_cnt", ad_log.size(), 4);
    chk("t036_a0", ad_log[0], 12'hFFE);
    chk("t036_a1", ad_log[1], 12'hFFF);
    chk("t036_a2", ad_log[2], 12'h000);
    chk("t036_a3", ad_log[3], 12'h001);
    chk("t036_le", {le_log[0], le_log[1], le_log[2], le_log[3]}, 8'h03);

    // LEN=0 write then LEN=0 read back-to-back
    d0 = done_cnt;
    snk_log.delete();
    send_cmd(1'b0, 12'h100, 12'd0, 1'b0, 1'b0, 1'b1);
    send_cmd(1'b1, 12'h100, 12'd0, 1'b0, 1'b1, 1'b0);
    chk("t039_done2", done_cnt - d0, 2);
    chk("t039_rd", snk_log.size() == 1 ? snk_log[0] : 5'h00, 5'h11);

    // Sink stalled: only 4 addresses go out, then drain 8 words
    snk_block = 1'b1;
    ad_log.delete();
    s0 = snk_cnt;
    send_cmd(1'b1, 12'h200, 12'd7, 1'b0, 1'b0, 1'b0);
    repeat (30) @(posedge clk);
    chk("t037_stall_out", outst, 4);
    chk("t037_stall_addrs", ad_log.size(), 4);
    snk_block = 1'b0;
    wait_done();
    chk("t037_words", snk_cnt - s0, 8);

    // Reset with 2 reads outstanding, then verify credits are back
    snk_block = 1'b1;
    send_cmd(1'b1, 12'h300, 12'd7, 1'b0, 1'b0, 1'b0);
    n = 0;
    while (outst < 2 && n < 100) begin
      @(posedge clk);
      n++;
    end
    chk("t040_two_out", outst, 2);
    d0 = done_cnt;
    do_reset();
    chk("t040_no_done", done_cnt - d0, 0);
    ad_log.delete();
    send_cmd(1'b1, 12'h300, 12'd7, 1'b0, 1'b0, 1'b0);
    repeat (30) @(posedge clk);
    chk("t040_credits", ad_log.size(), 4);
    snk_block = 1'b0;
    wait_done();
    send_cmd(1'b0, 12'h300, 12'd5, 1'b0, 1'b1, 1'b0);
    send_cmd(1'b1, 12'h300, 12'd5, 1'b1, 1'b1, 1'b0);

    // Random backpressure, write then read back
    rnd_on = 1'b1;
    for (int k = 0; k < 8; k++) begin
      logic [11:0] b;
      logic [11:0] l;
      b = 12'($urandom_range(0, 4095));
      l = 12'($urandom_range(0, 20));
      send_cmd(1'b0, b, l, 1'b0, 1'b1, 1'b0);
      send_cmd(1'b1, b, l, 1'($urandom_range(0, 1)), 1'b1, 1'b0);
    end
    rnd_on = 1'b0;
    repeat (3) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
